// File: rtl/sim_chk_pkg.sv
// Shared types and helpers for the simulation result checker.
// Build option SIM_CHK_RDCYCLE_EN (see sim_chk_shadow) does not change anything here.
package sim_chk_pkg;

  localparam int unsigned DEF_ADDR_W   = 14;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUM_GOLD = 64;
  localparam int unsigned DEF_IDX_W    = $clog2(DEF_NUM_GOLD);

  localparam logic [DEF_DATA_W-1:0] DEF_END_CODE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CHECK,
    DONE
  } state_e;

  typedef struct packed {
    logic [DEF_IDX_W-1:0]  idx;
    logic [DEF_DATA_W-1:0] got;
    logic [DEF_DATA_W-1:0] exp;
  } mis_rec_t;

  // Overlay the byte lanes selected by be onto the previous word.
  function automatic logic [DEF_DATA_W-1:0] byte_merge(
    input logic [DEF_DATA_W-1:0]   old_w,
    input logic [DEF_DATA_W-1:0]   new_w,
    input logic [DEF_DATA_W/8-1:0] be
  );
    logic [DEF_DATA_W-1:0] m;
    m = old_w;
    for (int unsigned b = 0; b < DEF_DATA_W / 8; b++) begin
      if (be[b]) m[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/sim_result_checker_if.sv
// Data-memory write port as snooped by the result checker.
// Build option SIM_CHK_RDCYCLE_EN does not affect this interface.
interface sim_result_checker_if
  import sim_chk_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic                  dm_we;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W/8-1:0]   dm_be;

  modport master (output dm_we, dm_addr, dm_wdata, dm_be);
  modport slave  (input  dm_we, dm_addr, dm_wdata, dm_be);

endinterface

// File: rtl/sim_chk_shadow.sv
// Shadow copy of the result window and sentinel word, fed from the snooped DM bus.
// With SIM_CHK_RDCYCLE_EN the two words after the golden range also form prog_cycle.
module sim_chk_shadow
  import sim_chk_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] TEST_START = 14'h2000,
  parameter logic [ADDR_W-1:0] SIM_END    = 14'h3fff,
  parameter logic [DATA_W-1:0] END_CODE   = DEF_END_CODE,
  parameter int unsigned       NUM_GOLD   = DEF_NUM_GOLD,
  localparam int unsigned      IDX_W      = $clog2(NUM_GOLD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  run,
  sim_result_checker_if.slave   dm,
`ifdef SIM_CHK_RDCYCLE_EN
  input  logic [IDX_W:0]        num,
`endif
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  sent_hit,
  output logic [2*DATA_W-1:0]   prog_cycle
);

  localparam logic [ADDR_W-1:0] WIN_LEN = ADDR_W'(NUM_GOLD);

  logic [DATA_W-1:0] shadow_q [NUM_GOLD];
  logic [DATA_W-1:0] shadow_d [NUM_GOLD];
  logic [DATA_W-1:0] sent_q, sent_d, sent_merged;
  logic [ADDR_W-1:0] off;
  logic              wr, win_hit, sent_sel;

  assign wr          = run && dm.dm_we;
  assign off         = dm.dm_addr - TEST_START;
  assign win_hit     = wr && (dm.dm_addr >= TEST_START) && (off < WIN_LEN);
  assign sent_sel    = wr && (dm.dm_addr == SIM_END);
  assign sent_merged = byte_merge(sent_q, dm.dm_wdata, dm.dm_be);
  // Partial sentinel writes accumulate; only the merged word is tested.
  assign sent_hit    = sent_sel && (sent_merged == END_CODE);
  assign rd_data     = shadow_q[rd_idx];

  always_comb begin
    shadow_d = shadow_q;
    sent_d   = sent_q;
    if (clr) begin
      shadow_d = '{default: '0};
      sent_d   = '0;
    end else begin
      if (win_hit) begin
        shadow_d[off[IDX_W-1:0]] = byte_merge(shadow_q[off[IDX_W-1:0]], dm.dm_wdata, dm.dm_be);
      end
      if (sent_sel) sent_d = sent_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '{default: '0};
      sent_q   <= '0;
    end else begin
      shadow_q <= shadow_d;
      sent_q   <= sent_d;
    end
  end

`ifdef SIM_CHK_RDCYCLE_EN
  logic [DATA_W-1:0] plo_q, plo_d, phi_q, phi_d;
  logic [ADDR_W-1:0] lo_addr, hi_addr;

  assign lo_addr = TEST_START + ADDR_W'(num);
  assign hi_addr = lo_addr + ADDR_W'(1);

  always_comb begin
    plo_d = plo_q;
    phi_d = phi_q;
    if (clr) begin
      plo_d = '0;
      phi_d = '0;
    end else if (wr) begin
      if (dm.dm_addr == lo_addr) plo_d = byte_merge(plo_q, dm.dm_wdata, dm.dm_be);
      if (dm.dm_addr == hi_addr) phi_d = byte_merge(phi_q, dm.dm_wdata, dm.dm_be);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plo_q <= '0;
      phi_q <= '0;
    end else begin
      plo_q <= plo_d;
      phi_q <= phi_d;
    end
  end

  assign prog_cycle = {phi_q, plo_q};
`else
  assign prog_cycle = '0;
`endif

endmodule

// File: rtl/sim_result_checker.sv
// End-of-simulation monitor: waits for sentinel or timeout, then compares shadow vs golden.
// Optional build macro SIM_CHK_RDCYCLE_EN enables the prog_cycle report.
module sim_result_checker
  import sim_chk_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] TEST_START = 14'h2000,
  parameter logic [ADDR_W-1:0] SIM_END    = 14'h3fff,
  parameter logic [DATA_W-1:0] END_CODE   = DEF_END_CODE,
  parameter int unsigned       NUM_GOLD   = DEF_NUM_GOLD,
  parameter int unsigned       MAX_CYCLE  = 100000,
  parameter int unsigned       CNT_W      = 64,
  localparam int unsigned      IDX_W      = $clog2(NUM_GOLD),
  localparam int unsigned      NUM_W      = IDX_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                gld_we,
  input  logic [IDX_W-1:0]    gld_idx,
  input  logic [DATA_W-1:0]   gld_data,
  input  logic [NUM_W-1:0]    gld_num,
  sim_result_checker_if.slave dm,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [NUM_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    total_cycle,
  output logic                mis_valid,
  output logic [IDX_W-1:0]    mis_idx,
  output logic [DATA_W-1:0]   mis_got,
  output logic [DATA_W-1:0]   mis_exp,
  output logic [63:0]         prog_cycle
);

  localparam logic [NUM_W-1:0] NUM_MAX  = NUM_W'(NUM_GOLD);
  localparam logic [CNT_W-1:0] TOT_LAST = CNT_W'(MAX_CYCLE - 1);

  state_e            state_q, state_d;
  logic [NUM_W-1:0]  num_q, num_d, idx_q, idx_d, err_q, err_d;
  logic [CNT_W-1:0]  tot_q, tot_d;
  logic              to_q, to_d, mis_v_q, mis_v_d;
  mis_rec_t          mis_q, mis_d;
  logic [DATA_W-1:0] gold_q [NUM_GOLD];
  logic [DATA_W-1:0] gold_d [NUM_GOLD];
  logic [DATA_W-1:0] rd_data;
  logic              sent_hit, idle_or_done, clr;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign clr          = idle_or_done && start;

  sim_chk_shadow #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TEST_START (TEST_START),
    .SIM_END    (SIM_END),
    .END_CODE   (END_CODE),
    .NUM_GOLD   (NUM_GOLD)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .run        (state_q == RUN),
    .dm         (dm),
`ifdef SIM_CHK_RDCYCLE_EN
    .num        (num_q),
`endif
    .rd_idx     (idx_q[IDX_W-1:0]),
    .rd_data    (rd_data),
    .sent_hit   (sent_hit),
    .prog_cycle (prog_cycle)
  );

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    idx_d   = idx_q;
    err_d   = err_q;
    tot_d   = tot_q;
    to_d    = to_q;
    mis_v_d = 1'b0;
    mis_d   = mis_q;
    gold_d  = gold_q;
    if (idle_or_done && gld_we) gold_d[gld_idx] = gld_data;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          num_d   = (gld_num > NUM_MAX) ? NUM_MAX : gld_num;
          idx_d   = '0;
          err_d   = '0;
          tot_d   = '0;
          to_d    = 1'b0;
          mis_d   = '0;
        end
      end
      RUN: begin
        tot_d = tot_q + CNT_W'(1);
        if (sent_hit) begin
          state_d = CHECK;
        end else if (tot_q == TOT_LAST) begin
          state_d = CHECK;
          to_d    = 1'b1;
        end
      end
      CHECK: begin
        if ((idx_q < num_q) && (rd_data != gold_q[idx_q[IDX_W-1:0]])) begin
          mis_v_d = 1'b1;
          mis_d   = '{idx: idx_q[IDX_W-1:0], got: rd_data, exp: gold_q[idx_q[IDX_W-1:0]]};
          err_d   = err_q + NUM_W'(1);
        end
        // A single CHECK cycle still elapses when num is zero.
        if (idx_q + NUM_W'(1) >= num_q) begin
          state_d = DONE;
          if (to_q) err_d = num_q;
        end else begin
          idx_d = idx_q + NUM_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      tot_q   <= '0;
      to_q    <= 1'b0;
      mis_v_q <= 1'b0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      tot_q   <= tot_d;
      to_q    <= to_d;
      mis_v_q <= mis_v_d;
      mis_q   <= mis_d;
    end
  end

  // Golden table survives reset so the loader need not rerun after an abort.
  always_ff @(posedge clk) begin
    gold_q <= gold_d;
  end

  assign busy        = (state_q == RUN) || (state_q == CHECK);
  assign done        = (state_q == DONE);
  assign pass        = done && (err_q == '0) && !to_q;
  assign timeout     = to_q;
  assign err_cnt     = err_q;
  assign total_cycle = tot_q;
  assign mis_valid   = mis_v_q;
  assign mis_idx     = mis_q.idx;
  assign mis_got     = mis_q.got;
  assign mis_exp     = mis_q.exp;

endmodule
